// File: rtl/easyaxi_pkg.sv
// -----------------------------------------------------------------------------
// easyaxi_pkg
// Shared definitions for the EasyAXI master sequencer:
//   - sequencer FSM state encoding (3-bit, legacy-compatible constants)
//   - AXI response codes OKAY / EXOKAY / SLVERR / DECERR
//   - default parameter values used by easyaxi_mst_seq
//   - rsp_is_err(): classifies a response code as an error
// -----------------------------------------------------------------------------
package easyaxi_pkg;

    // Sequencer FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_DRAIN = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_ABORT    = 3'd6;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Default parameter values
    localparam int          DEF_ADDR_WIDTH = 32;
    localparam int          DEF_ID_WIDTH   = 4;
    localparam int          DEF_LEN_WIDTH  = 8;
    localparam int          DEF_NUM_TXN    = 16;
    localparam int          DEF_MAX_OUTSTD = 4;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEF_ADDR_STEP  = 32'h0000_0040;
    localparam logic [7:0]  DEF_BURST_LEN  = 8'd3;

    // Only OKAY counts as success; EXOKAY is unexpected here since the
    // sequencer never issues exclusive accesses.
    function automatic logic rsp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/easyaxi_outstd_cnt.sv
// -----------------------------------------------------------------------------
// easyaxi_outstd_cnt
// Up/down counter of commands issued but not yet responded.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (dominates inc/dec)
//   inc        : one command handshaken this cycle
//   dec        : one response received this cycle
//   cnt        : current count
//   full       : cnt == MAX_OUTSTD
//   empty      : cnt == 0
// A decrement at zero is ignored so a stray response cannot underflow.
// -----------------------------------------------------------------------------
module easyaxi_outstd_cnt
#(
    parameter int MAX_OUTSTD = 4,
    parameter int CNT_W      = $clog2(MAX_OUTSTD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic dec_eff;

    assign dec_eff = dec && (cnt != '0);
    assign full    = (cnt == CNT_W'(MAX_OUTSTD));
    assign empty   = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec_eff) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!inc && dec_eff) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/easyaxi_mst_seq.sv
// -----------------------------------------------------------------------------
// easyaxi_mst_seq
// Transaction sequencer between the EasyAXI enable/done control and the AXI
// master core command/response interface. On enable it issues NUM_TXN write
// bursts at BASE_ADDR + n*ADDR_STEP, waits for all write responses, then
// issues the same address sequence as reads. Outstanding commands are capped
// at MAX_OUTSTD; any bad response raises a sticky err.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : level run request; dropping it aborts the run
//   done                  : both phases complete (held until enable drops)
//   err                   : sticky error, cleared when a new run starts
//   cmd_valid / cmd_ready : command handshake
//   cmd_write             : 1 = write, 0 = read
//   cmd_addr, cmd_len, cmd_id : command payload
//   rsp_valid             : response pulse (always accepted)
//   rsp_id, rsp_resp      : response ID and AXI resp code
// Build option: define EASYAXI_SEQ_ID_CHECK_EN to require responses to come
// back in issue order (rsp_id mismatch sets err).
// -----------------------------------------------------------------------------
module easyaxi_mst_seq
    import easyaxi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    ID_WIDTH   = DEF_ID_WIDTH,
    parameter int                    LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int                    NUM_TXN    = DEF_NUM_TXN,
    parameter int                    MAX_OUTSTD = DEF_MAX_OUTSTD,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DEF_ADDR_STEP),
    parameter logic [LEN_WIDTH-1:0]  BURST_LEN  = LEN_WIDTH'(DEF_BURST_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  done,
    output logic                  err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ID_WIDTH-1:0]   cmd_id,
    input  logic                  rsp_valid,
    input  logic [ID_WIDTH-1:0]   rsp_id,
    input  logic [1:0]            rsp_resp
);

    localparam int ISSUE_W = $clog2(NUM_TXN + 1);
    localparam int CNT_W   = $clog2(MAX_OUTSTD + 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ISSUE_W-1:0]    issue_cnt;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic                  err_q;
    logic [CNT_W-1:0]      outstd;
    logic                  outstd_full;
    logic                  outstd_empty;

    logic is_issue;
    logic hs;
    logic last_hs;
    logic run_start;
    logic rd_start;
    logic phase_start;
    logic id_bad;

    assign is_issue    = (state == ST_WR_ISSUE) || (state == ST_RD_ISSUE);
    assign cmd_valid   = is_issue && (issue_cnt < ISSUE_W'(NUM_TXN)) && !outstd_full;
    assign hs          = cmd_valid && cmd_ready;
    assign last_hs     = hs && (issue_cnt == ISSUE_W'(NUM_TXN - 1));
    assign run_start   = (state == ST_IDLE) && enable;
    assign rd_start    = (state == ST_WR_DRAIN) && enable && outstd_empty;
    assign phase_start = run_start || rd_start;

    // Payload is derived from registered state only, so it cannot move while
    // cmd_valid waits for cmd_ready.
    assign cmd_write = (state == ST_WR_ISSUE);
    assign cmd_addr  = addr_acc;
    assign cmd_len   = BURST_LEN;
    assign cmd_id    = ID_WIDTH'(issue_cnt);
    assign done      = (state == ST_DONE);
    assign err       = err_q;

    easyaxi_outstd_cnt #(
        .MAX_OUTSTD (MAX_OUTSTD),
        .CNT_W      (CNT_W)
    ) u_outstd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (hs),
        .dec   (rsp_valid),
        .cnt   (outstd),
        .full  (outstd_full),
        .empty (outstd_empty)
    );

`ifdef EASYAXI_SEQ_ID_CHECK_EN
    logic [ID_WIDTH-1:0] exp_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_id <= '0;
        end else if (phase_start) begin
            exp_id <= '0;
        end else if (rsp_valid) begin
            exp_id <= exp_id + ID_WIDTH'(1);
        end
    end

    assign id_bad = (rsp_id != exp_id);
`else
    logic unused_rsp_id;
    assign unused_rsp_id = ^rsp_id;
    assign id_bad        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WR_ISSUE;
            end
            ST_WR_ISSUE, ST_RD_ISSUE: begin
                // A command already presented must complete before aborting.
                if (!enable && (!cmd_valid || hs)) begin
                    state_nxt = ST_ABORT;
                end else if (last_hs) begin
                    state_nxt = (state == ST_WR_ISSUE) ? ST_WR_DRAIN : ST_RD_DRAIN;
                end
            end
            ST_WR_DRAIN: begin
                if (!enable)          state_nxt = ST_ABORT;
                else if (outstd_empty) state_nxt = ST_RD_ISSUE;
            end
            ST_RD_DRAIN: begin
                if (!enable)          state_nxt = ST_ABORT;
                else if (outstd_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!enable) state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                if (outstd_empty) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            issue_cnt <= '0;
            addr_acc  <= BASE_ADDR;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;

            // Address accumulator wraps naturally at 2^ADDR_WIDTH.
            if (phase_start) begin
                issue_cnt <= '0;
                addr_acc  <= BASE_ADDR;
            end else if (hs) begin
                issue_cnt <= issue_cnt + ISSUE_W'(1);
                addr_acc  <= addr_acc + ADDR_STEP;
            end

            if (run_start) begin
                err_q <= 1'b0;
            end else if (rsp_valid && (rsp_is_err(rsp_resp) || outstd_empty || id_bad)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_mst_seq.sv
module tb_easyaxi_mst_seq;

`ifdef EASYAXI_SEQ_ID_CHECK_EN
    localparam bit ID_CHK = 1'b1;
`else
    localparam bit ID_CHK = 1'b0;
`endif

    typedef struct {
        bit         wrap;
        int         bad_idx;
        logic [1:0] bad_code;
        bit         swap;
        bit         exp_err;
    } run_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [3:0]  id;
    } exp_cmd_t;

    typedef struct {
        int         due;
        logic [3:0] id;
        logic [1:0] resp;
    } pend_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic sel;
    logic cmd_ready;
    logic rsp_valid;
    logic [3:0] rsp_id;
    logic [1:0] rsp_resp;

    logic en_a, en_w;
    logic a_done, a_err, a_cmd_valid, a_cmd_write;
    logic [31:0] a_cmd_addr;
    logic [7:0]  a_cmd_len;
    logic [3:0]  a_cmd_id;
    logic w_done, w_err, w_cmd_valid, w_cmd_write;
    logic [31:0] w_cmd_addr;
    logic [7:0]  w_cmd_len;
    logic [3:0]  w_cmd_id;

    logic done_m, err_m, cv_m, cw_m;
    logic [31:0] addr_m;
    logic [7:0]  len_m;
    logic [3:0]  id_m;

    assign en_a   = enable & ~sel;
    assign en_w   = enable & sel;
    assign done_m = sel ? w_done      : a_done;
    assign err_m  = sel ? w_err       : a_err;
    assign cv_m   = sel ? w_cmd_valid : a_cmd_valid;
    assign cw_m   = sel ? w_cmd_write : a_cmd_write;
    assign addr_m = sel ? w_cmd_addr  : a_cmd_addr;
    assign len_m  = sel ? w_cmd_len   : a_cmd_len;
    assign id_m   = sel ? w_cmd_id    : a_cmd_id;

    easyaxi_mst_seq #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .NUM_TXN(4), .MAX_OUTSTD(2),
        .BASE_ADDR(32'h0000_1000), .ADDR_STEP(32'h40), .BURST_LEN(8'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .done(a_done), .err(a_err),
        .cmd_valid(a_cmd_valid), .cmd_ready(cmd_ready), .cmd_write(a_cmd_write),
        .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len), .cmd_id(a_cmd_id),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp)
    );

    easyaxi_mst_seq #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .NUM_TXN(4), .MAX_OUTSTD(2),
        .BASE_ADDR(32'hFFFF_FF80), .ADDR_STEP(32'h40), .BURST_LEN(8'd3)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(en_w), .done(w_done), .err(w_err),
        .cmd_valid(w_cmd_valid), .cmd_ready(cmd_ready), .cmd_write(w_cmd_write),
        .cmd_addr(w_cmd_addr), .cmd_len(w_cmd_len), .cmd_id(w_cmd_id),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int hs_base = 0;
    int mod_out = 0;
    int max_seen = 0;
    bit cap_viol = 0;
    bit done_seen = 0;
    bit auto_rsp = 0;
    int bad_idx = -1;
    logic [1:0] bad_code = 2'b00;
    bit swap = 0;
    logic man_valid = 1'b0;
    logic [3:0] man_id = '0;
    logic [1:0] man_resp = '0;
    exp_cmd_t sbq[$];
    pend_t    pend[$];
    run_t     tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_phase(input logic [31:0] base, input int n, input logic w);
        exp_cmd_t e;
        for (int i = 0; i < n; i++) begin
            e.w    = w;
            e.addr = base + 32'(i) * 32'h40;
            e.id   = 4'(i);
            sbq.push_back(e);
        end
    endtask

    // One clock cycle: drive responses and monitor at the falling edge,
    // return just after the next rising edge.
    task automatic tick();
        logic   hs;
        logic   fire;
        logic [3:0] f_id;
        logic [1:0] f_resp;
        pend_t  p;
        exp_cmd_t e;
        int     idx;
        @(negedge clk);
        cyc++;
        fire = 1'b0; f_id = '0; f_resp = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            fire = 1'b1; f_id = p.id; f_resp = p.resp;
        end
        rsp_valid = man_valid | fire;
        rsp_id    = man_valid ? man_id : f_id;
        rsp_resp  = man_valid ? man_resp : f_resp;
        hs = cv_m && cmd_ready;
        if (cv_m && mod_out >= 2) cap_viol = 1'b1;
        if (hs) begin
            idx = hs_cnt - hs_base;
            hs_cnt++;
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd: got addr %0h id %0h, want none", addr_m, id_m);
            end else begin
                e = sbq.pop_front();
                chk("cmd_write", cw_m, e.w);
                chk("cmd_addr", addr_m, e.addr);
                chk("cmd_id", id_m, e.id);
                chk("cmd_len", len_m, 8'd3);
            end
            if (auto_rsp) begin
                p.due  = cyc + 2;
                p.id   = id_m;
                if (swap && idx == 0) p.id = 4'd1;
                if (swap && idx == 1) p.id = 4'd0;
                p.resp = (idx == bad_idx) ? bad_code : 2'b00;
                pend.push_back(p);
            end
        end
        if (hs && !(rsp_valid && mod_out > 0)) mod_out++;
        else if (!hs && rsp_valid && mod_out > 0) mod_out--;
        if (mod_out > max_seen) max_seen = mod_out;
        if (done_m) done_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 150; k++) begin
            if (done_m) break;
            tick();
        end
        chk("done_reached", done_m, 1'b1);
    endtask

    task automatic run_entry(input run_t r);
        logic [31:0] base;
        sel = r.wrap; bad_idx = r.bad_idx; bad_code = r.bad_code; swap = r.swap;
        auto_rsp = 1'b1; hs_base = hs_cnt; cmd_ready = 1'b1;
        base = r.wrap ? 32'hFFFF_FF80 : 32'h0000_1000;
        sbq.delete();
        push_phase(base, 4, 1'b1);
        push_phase(base, 4, 1'b0);
        chk("idle_no_valid", cv_m, 1'b0);
        enable = 1'b1;
        tick();
        chk("start_valid", cv_m, 1'b1);
        wait_done();
        chk("err_at_done", err_m, r.exp_err);
        chk("all_cmds_seen", sbq.size(), 0);
        enable = 1'b0;
        tick();
        chk("done_fall", done_m, 1'b0);
        tick();
        swap = 1'b0; bad_idx = -1;
    endtask

    initial begin
        tbl[0] = '{wrap: 1'b0, bad_idx: -1, bad_code: 2'b00, swap: 1'b0, exp_err: 1'b0};
        tbl[1] = '{wrap: 1'b0, bad_idx:  2, bad_code: 2'b10, swap: 1'b0, exp_err: 1'b1};
        tbl[2] = '{wrap: 1'b0, bad_idx: -1, bad_code: 2'b00, swap: 1'b0, exp_err: 1'b0};
        tbl[3] = '{wrap: 1'b0, bad_idx:  5, bad_code: 2'b11, swap: 1'b0, exp_err: 1'b1};
        tbl[4] = '{wrap: 1'b1, bad_idx: -1, bad_code: 2'b00, swap: 1'b0, exp_err: 1'b0};
        tbl[5] = '{wrap: 1'b0, bad_idx: -1, bad_code: 2'b00, swap: 1'b1, exp_err: ID_CHK};

        rst_n = 1'b0; enable = 1'b0; sel = 1'b0; cmd_ready = 1'b1;
        rsp_valid = 1'b0; rsp_id = '0; rsp_resp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", a_done, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_valid", a_cmd_valid, 1'b0);
        chk("rst_write", a_cmd_write, 1'b0);
        chk("rst_addr", a_cmd_addr, 32'h0000_1000);
        chk("rst_id", a_cmd_id, 4'd0);
        chk("rst_len", a_cmd_len, 8'd3);
        chk("rst_addr_w", w_cmd_addr, 32'hFFFF_FF80);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", a_cmd_valid, 1'b0);

        for (int i = 0; i < 6; i++) run_entry(tbl[i]);

        // Withheld responses: cap of two outstanding commands
        sel = 1'b0; auto_rsp = 1'b0; cmd_ready = 1'b1; hs_base = hs_cnt;
        max_seen = 0; cap_viol = 1'b0; done_seen = 1'b0;
        sbq.delete();
        push_phase(32'h0000_1000, 3, 1'b1);
        enable = 1'b1;
        repeat (10) tick();
        chk("cap_hs_count", hs_cnt - hs_base, 2);
        chk("cap_valid_low", cv_m, 1'b0);
        man_valid = 1'b1; man_id = 4'd0; man_resp = 2'b00;
        tick();
        man_valid = 1'b0;
        tick(); tick();
        chk("cap_resume_hs", hs_cnt - hs_base, 3);
        enable = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            man_valid = 1'b1; man_id = 4'(k);
            tick();
        end
        man_valid = 1'b0;
        repeat (4) tick();
        chk("cap_max_outstd", max_seen, 2);
        chk("cap_no_viol", cap_viol, 1'b0);
        chk("cap_err", err_m, 1'b0);
        chk("cap_sb_empty", sbq.size(), 0);
        chk("cap_no_done", done_seen, 1'b0);

        // Abort with a stalled command pending
        auto_rsp = 1'b1; cmd_ready = 1'b0; hs_base = hs_cnt; done_seen = 1'b0;
        sbq.delete();
        push_phase(32'h0000_1000, 1, 1'b1);
        enable = 1'b1;
        tick();
        chk("abort_start_valid", cv_m, 1'b1);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_hold_valid", cv_m, 1'b1);
            chk("abort_hold_addr", addr_m, 32'h0000_1000);
        end
        cmd_ready = 1'b1;
        tick();
        chk("abort_no_issue", cv_m, 1'b0);
        repeat (6) tick();
        chk("abort_no_issue_late", cv_m, 1'b0);
        chk("abort_no_done", done_seen, 1'b0);
        chk("abort_sb_empty", sbq.size(), 0);
        chk("abort_hs_count", hs_cnt - hs_base, 1);

        // Back in IDLE: a clean run starts immediately
        run_entry(tbl[0]);

        // Stray response while nothing is outstanding
        sel = 1'b0; auto_rsp = 1'b1; cmd_ready = 1'b0; hs_base = hs_cnt;
        sbq.delete();
        push_phase(32'h0000_1000, 4, 1'b1);
        push_phase(32'h0000_1000, 4, 1'b0);
        enable = 1'b1;
        tick();
        chk("stray_err_before", err_m, 1'b0);
        man_valid = 1'b1; man_id = 4'd0; man_resp = 2'b00;
        tick();
        man_valid = 1'b0;
        chk("stray_err", err_m, 1'b1);
        chk("stray_no_underflow", cv_m, 1'b1);
        cmd_ready = 1'b1;
        wait_done();
        chk("stray_err_sticky", err_m, 1'b1);
        chk("stray_sb_empty", sbq.size(), 0);
        enable = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
